// File: rtl/mod12_display_driver_if.sv
// Bus between the mod-12 counter side and the display driver.
// The master side supplies the count and controls; the slave side returns digits and display drive.
interface mod12_display_driver_if;
  logic [3:0] count;
  logic       en;
  logic       err_clr;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;
  logic       err;

  modport master (
    output count, en, err_clr,
    input  bcd_tens, bcd_ones, seg, an, wrap, err
  );

  modport slave (
    input  count, en, err_clr,
    output bcd_tens, bcd_ones, seg, an, wrap, err
  );
endinterface

// File: rtl/mod12_display_driver.sv
// Mod-12 count to two BCD digits, multiplexed 7-segment scan with leading-zero
// blanking, wrap pulse on 11->0 and a sticky out-of-range error.
module mod12_display_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mod12_display_driver_if.slave   bus
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  typedef enum logic {SLOT_ONES = 1'b0, SLOT_TENS = 1'b1} slot_t;

  slot_t         r_slot, w_slot_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [3:0]    r_cnt_q;
  logic [3:0]    r_tens, r_ones;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;
  logic          r_wrap, r_err;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  // Sample stage, BCD stage, wrap detect and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_q <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt_q <= bus.count;
      if (r_cnt_q <= 4'd9) begin
        r_tens <= 4'd0;
        r_ones <= r_cnt_q;
      end else if (r_cnt_q <= 4'd11) begin
        r_tens <= 4'd1;
        r_ones <= r_cnt_q - 4'd10;
      end else begin
        r_tens <= 4'hF;
        r_ones <= 4'hF;
      end
      r_wrap <= (r_cnt_q == 4'd11) && (bus.count == 4'd0);
      if (bus.count > 4'd11)  r_err <= 1'b1;
      else if (bus.err_clr)   r_err <= 1'b0;
    end
  end

  // Scan slot state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot  <= SLOT_ONES;
      r_presc <= '0;
    end else begin
      r_slot  <= w_slot_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  always_comb begin
    w_slot_nxt  = r_slot;
    w_presc_nxt = r_presc;
    if (!bus.en) begin
      w_slot_nxt  = SLOT_ONES;
      w_presc_nxt = '0;
    end else if (r_presc == PMAX) begin
      w_presc_nxt = '0;
      w_slot_nxt  = (r_slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end else begin
      w_presc_nxt = r_presc + PW'(1);
    end
  end

  // A zero tens digit is blanked but its slot still lights its anode
  always_comb begin
    w_digit = (r_slot == SLOT_TENS) ? r_tens : r_ones;
    w_seg   = seg7(w_digit);
    if (r_slot == SLOT_TENS && r_tens == 4'd0) w_seg = 7'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= '0;
      r_an  <= '0;
    end else if (!bus.en) begin
      r_seg <= '0;
      r_an  <= 2'b00;
    end else begin
      r_seg <= w_seg;
      r_an  <= (r_slot == SLOT_TENS) ? 2'b10 : 2'b01;
    end
  end

  assign bus.bcd_tens = r_tens;
  assign bus.bcd_ones = r_ones;
  assign bus.seg      = r_seg;
  assign bus.an       = r_an;
  assign bus.wrap     = r_wrap;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_mod12_display_driver.sv
// Directed bench for mod12_display_driver: BCD scoreboard queue plus a cycle model of scan/wrap/err.
module tb_mod12_display_driver;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  mod12_display_driver_if bus();

  mod12_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wrap_seen;

  logic [7:0] q[$];
  logic [3:0] m_cnt, m_tens, m_ones;
  int         m_presc;
  logic       m_sel;
  logic [6:0] e_seg;
  logic [1:0] e_an;
  logic       e_wrap, e_err;

  function automatic logic [7:0] bcd_of(input logic [3:0] c);
    if (c < 4'd10)      bcd_of = {4'd0, c};
    else if (c < 4'd12) bcd_of = {4'd1, c - 4'd10};
    else                bcd_of = 8'hFF;
  endfunction

  function automatic logic [6:0] seg_of(input logic sel, input logic [3:0] t, input logic [3:0] o);
    logic [3:0] d;
    d = sel ? t : o;
    if (sel && t == 4'd0) return 7'h00;
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".seg"},  32'(bus.seg), 0);
    chk({tag, ".an"},   32'(bus.an), 0);
    chk({tag, ".tens"}, 32'(bus.bcd_tens), 0);
    chk({tag, ".ones"}, 32'(bus.bcd_ones), 0);
    chk({tag, ".wrap"}, 32'(bus.wrap), 0);
    chk({tag, ".err"},  32'(bus.err), 0);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_tens = 0; m_ones = 0; m_presc = 0; m_sel = 0;
    e_seg = 0; e_an = 0; e_wrap = 0; e_err = 0;
    q.delete();
    q.push_back(bcd_of(4'd0));
  endtask

  // Drive at a falling edge, predict the next rising edge, check at the following falling edge
  task automatic step(input logic [3:0] c, input logic e, input logic clr);
    logic [7:0] b, exp;
    bus.count = c; bus.en = e; bus.err_clr = clr;
    e_seg = e ? seg_of(m_sel, m_tens, m_ones) : 7'h00;
    e_an  = e ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
    if (e) begin
      if (m_presc == SCAN_DIV - 1) begin m_presc = 0; m_sel = ~m_sel; end
      else m_presc++;
    end else begin
      m_presc = 0; m_sel = 0;
    end
    b = bcd_of(m_cnt);
    m_tens = b[7:4]; m_ones = b[3:0];
    e_wrap = (m_cnt == 4'd11) && (c == 4'd0);
    e_err  = (c > 4'd11) ? 1'b1 : (clr ? 1'b0 : e_err);
    m_cnt  = c;
    q.push_back(bcd_of(c));
    @(negedge clk);
    chk("seg",  32'(bus.seg),  32'(e_seg));
    chk("an",   32'(bus.an),   32'(e_an));
    chk("wrap", 32'(bus.wrap), 32'(e_wrap));
    chk("err",  32'(bus.err),  32'(e_err));
    if (q.size() == 2) begin
      exp = q.pop_front();
      chk("bcd_tens", 32'(bus.bcd_tens), 32'(exp[7:4]));
      chk("bcd_ones", 32'(bus.bcd_ones), 32'(exp[3:0]));
    end
    if (bus.wrap) wrap_seen++;
  endtask

  initial begin
    rst = 1'b0;
    bus.count = 4'h7; bus.en = 1'b0; bus.err_clr = 1'b0;
    #1 chk_all_zero("rst_t0");
    @(negedge clk); chk_all_zero("rst_c1");
    @(negedge clk); chk_all_zero("rst_c2");

    rst = 1'b1;
    model_reset();
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);

    // Full count sequence with wrap back to 0
    wrap_seen = 0;
    for (int i = 0; i < 12; i++) step(4'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(4'd0, 1'b0, 1'b0);
    chk("wrap_once", 32'(wrap_seen), 1);

    // Non-wrapping loads
    wrap_seen = 0;
    step(4'd11, 1'b0, 1'b0); step(4'd5, 1'b0, 1'b0);
    step(4'd10, 1'b0, 1'b0); step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);  step(4'd0, 1'b0, 1'b0);
    chk("wrap_none", 32'(wrap_seen), 0);

    // Scan with 11 then 3 (tens blanked)
    for (int i = 0; i < 20; i++) step(4'd11, 1'b1, 1'b0);
    chk("seg_11", 32'(bus.seg), 32'h06);
    for (int i = 0; i < 20; i++) begin
      step(4'd3, 1'b1, 1'b0);
      if (i > 4 && bus.an == 2'b01) chk("seg_3_ones", 32'(bus.seg), 32'h4F);
      if (i > 4 && bus.an == 2'b10) chk("seg_3_tens", 32'(bus.seg), 32'h00);
    end

    // Sticky error, clear, and set-wins
    step(4'd13, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    chk("err_sticky", 32'(bus.err), 1);
    step(4'd2, 1'b1, 1'b1);
    chk("err_cleared", 32'(bus.err), 0);
    step(4'd14, 1'b1, 1'b1);
    chk("err_set_wins", 32'(bus.err), 1);
    for (int i = 0; i < 6; i++) step(4'd2, 1'b1, 1'b0);

    // Drop en mid-slot; wrap and err still work
    step(4'd5, 1'b1, 1'b0); step(4'd5, 1'b1, 1'b0);
    step(4'd5, 1'b0, 1'b0);
    chk("en_off_an", 32'(bus.an), 0);
    step(4'd11, 1'b0, 1'b1); step(4'd0, 1'b0, 1'b0);
    chk("en_off_wrap", 32'(bus.wrap), 1);
    step(4'd12, 1'b0, 1'b0); step(4'd4, 1'b0, 1'b0);
    chk("en_off_err", 32'(bus.err), 1);
    for (int i = 0; i < 6; i++) step(4'd4, 1'b1, 1'b0);

    // Asynchronous reset mid-scan
    #7 rst = 1'b0;
    #1 chk_all_zero("rst_async");
    @(negedge clk);
    chk_all_zero("rst_held");
    rst = 1'b1;
    model_reset();
    step(4'd10, 1'b1, 1'b0);
    chk("resume_an", 32'(bus.an), 32'b01);
    for (int i = 0; i < 12; i++) step(4'd10, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $error("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
